if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage directly downstream of the PC register.
- Issues instruction-memory requests for the current PC.
- Tolerates multi-cycle memory latency via a request/ack handshake.
- Loads the IF/ID pipeline register and produces Fetch_Stall, which is OR'd with the hazard Stall into the PC register.
- Handles redirect flushes and holds a fetched word while ID is stalled.

Parameters:
- DATA_W, 32, instruction/address width
- NOP_INSTR, 32'h0000_0000, bubble instruction inserted on flush/reset

Ports:
- Clk  in  1  clock, rising edge
- PcReSet  in  1  asynchronous, active-high reset
- PC  in  32  current PC from the PC register
- Change_PC_en  in  1  branch/jump redirect; PC takes new value at next edge
- Stall  in  1  hazard stall from ID
- Imem_Ack  in  1  memory has valid data on Imem_Rdata this cycle
- Imem_Rdata  in  32  instruction word
- Imem_Req  out  1  fetch request
- Imem_Addr  out  32  fetch address
- Fetch_Stall  out  1  combinational; blocks PC increment
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PC4  out  32  registered PC+4 of that instruction
- IF_ID_Valid  out  1  registered; 0 = bubble
- IF_ID_IsCtrl  out  1  registered predecode flag (see Optional Feature)

Behaviour:
- Reset (async, PcReSet=1): state=FETCH; IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_Valid=0, IF_ID_IsCtrl=0; hold buffer and discard address cleared. Any in-flight memory access is abandoned; memory shares PcReSet.
- Memory protocol: Req and Addr stay stable from assertion until the Ack cycle. Ack is accepted only while Req=1. Zero-wait memory may ack in the same cycle.
- Priority within a cycle: Change_PC_en > Stall > normal.
- State FETCH: Req=1, Addr=PC, Fetch_Stall=!Imem_Ack.
  - Ack & Change_PC_en: IF/ID <= bubble; stay FETCH.
  - Ack & Stall: IF/ID holds; buffer <= {Rdata, PC+4}; go HOLD.
  - Ack & neither: IF/ID <= {Rdata, PC+4, Valid=1}.
  - !Ack & Change_PC_en: discard address <= PC; IF/ID <= bubble; go DISCARD.
  - !Ack & Stall: IF/ID holds.
  - !Ack otherwise: IF/ID holds; stay FETCH.
- State DISCARD: Req=1, Addr=discard address, Fetch_Stall=1.
  - Returned data is dropped.
  - On Ack: go FETCH.
  - Any Change_PC_en (including with Ack): IF/ID <= bubble.
- State HOLD: Req=0, Addr=PC, Fetch_Stall=0.
  - Change_PC_en: IF/ID <= bubble; buffer dropped; go FETCH.
  - Stall=0: IF/ID <= {buffer, Valid=1}; go FETCH. PC advances at the same edge.
  - Stall=1: remain HOLD.
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC yields 0.
- Throughput: one instruction per cycle with zero-wait memory. Each wait cycle inserts no bubble; IF/ID simply holds. ID must treat a held entry as unchanged.
- No instruction is ever delivered for a PC that was redirected away from.

Optional Feature:
- Macro IF_PREDECODE_EN.
- When defined: IF_ID_IsCtrl is loaded with the word whenever IF/ID loads a valid instruction, and cleared on bubble. It is 1 when:
  - opcode[31:26] is 000010, 000011, 000100 or 000101, or
  - opcode is 000000 with funct[5:0] = 001000 or 001001.
- When undefined: IF_ID_IsCtrl is tied 0 and no predecode logic is synthesised.

Decomposition:
- Shared header bus_def.v holds: `Word_Bus, NOP constant, state encodings (FETCH/DISCARD/HOLD), and opcode/funct constants for j, jal, beq, bne, jr, jalr.
- One combinational sub-module, if_predecode (instruction in, IsCtrl out), instantiated only under IF_PREDECODE_EN.

Test Plan:
- Reset then zero-wait memory at PC 0x3000, 0x3004, 0x3008 -> IF_ID_PC4 = 0x3004, 0x3008, 0x300C on successive edges; Valid=1; Fetch_Stall=0 throughout.
- 2-cycle latency (Ack on 2nd request cycle) at PC 0x3000 -> Fetch_Stall=1 for exactly 1 cycle; IF/ID loads once with PC4=0x3004.
- Ack with Stall=1 for 3 cycles, word 0x8C010004 -> state HOLD, Req=0, IF/ID unchanged; on Stall=0, IF_ID_Instr=0x8C010004, Valid=1.
- Change_PC_en while a request to 0x3010 is pending -> IF/ID bubble (Valid=0, Instr=0); Imem_Addr stays 0x3010 until Ack; that data is dropped; next request uses the new PC.
- Change_PC_en in HOLD, and Change_PC_en together with Stall and Ack -> bubble, buffer discarded, no stale instruction ever reaches IF/ID.
- PcReSet asserted mid-wait, then with IF_PREDECODE_EN defined fetch 0x10220003 (beq) -> outputs reset immediately; after release, IsCtrl=1 for beq and 0 for 0x00221820 (add).

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared widths, bubble word, FSM encoding and control-flow opcodes
package if_fetch_stage_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetch_state_t;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
endpackage

// File: rtl/if_fetch_stage_predecode.sv
// if_predecode: flags jumps, branches and register jumps in a fetched word
module if_predecode
  import if_fetch_stage_pkg::*;
(
  input  logic [WORD_W-1:0] instr,
  output logic              is_ctrl
);
  logic [5:0] op, fn;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign is_ctrl = (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE}) ||
                   (op == OP_SPECIAL && (fn inside {FN_JR, FN_JALR}));
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: imem request/ack fetch into IF/ID with redirect discard and stall hold
// Optional predecode of IF_ID_IsCtrl is enabled by defining IF_PREDECODE_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                DATA_W    = WORD_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              Clk,
  input  logic              PcReSet,
  input  logic [DATA_W-1:0] PC,
  input  logic              Change_PC_en,
  input  logic              Stall,
  input  logic              Imem_Ack,
  input  logic [DATA_W-1:0] Imem_Rdata,
  output logic              Imem_Req,
  output logic [DATA_W-1:0] Imem_Addr,
  output logic              Fetch_Stall,
  output logic [DATA_W-1:0] IF_ID_Instr,
  output logic [DATA_W-1:0] IF_ID_PC4,
  output logic              IF_ID_Valid,
  output logic              IF_ID_IsCtrl
);
  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d, pc4_q, pc4_d;
  logic [DATA_W-1:0] buf_instr_q, buf_instr_d, buf_pc4_q, buf_pc4_d;
  logic [DATA_W-1:0] disc_addr_q, disc_addr_d, pc_plus4;
  logic              valid_q, valid_d;
  assign pc_plus4 = PC + DATA_W'(4);
  // state and IF/ID registers; reset abandons any in-flight access
  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      state_q     <= FETCH;
      instr_q     <= NOP_INSTR;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      disc_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      disc_addr_q <= disc_addr_d;
    end
  end
  // next state and IF/ID load: redirect beats stall beats normal advance
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    disc_addr_d = disc_addr_q;
    case (state_q)
      FETCH: begin
        if (Change_PC_en) begin
          {instr_d, pc4_d, valid_d} = {NOP_INSTR, {DATA_W{1'b0}}, 1'b0};
          if (!Imem_Ack) begin
            disc_addr_d = PC;
            state_d     = DISCARD;
          end
        end else if (Imem_Ack && Stall) begin
          {buf_instr_d, buf_pc4_d} = {Imem_Rdata, pc_plus4};
          state_d                  = HOLD;
        end else if (Imem_Ack) begin
          {instr_d, pc4_d, valid_d} = {Imem_Rdata, pc_plus4, 1'b1};
        end
      end
      DISCARD: begin
        if (Imem_Ack) state_d = FETCH;
        if (Change_PC_en) {instr_d, pc4_d, valid_d} = {NOP_INSTR, {DATA_W{1'b0}}, 1'b0};
      end
      HOLD: begin
        if (Change_PC_en) begin
          {instr_d, pc4_d, valid_d} = {NOP_INSTR, {DATA_W{1'b0}}, 1'b0};
          state_d                   = FETCH;
        end else if (!Stall) begin
          {instr_d, pc4_d, valid_d} = {buf_instr_q, buf_pc4_q, 1'b1};
          state_d                   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end
  // memory interface and fetch stall; discarded request keeps its address until acked
  always_comb begin
    Imem_Req    = state_q != HOLD;
    Imem_Addr   = state_q == DISCARD ? disc_addr_q : PC;
    Fetch_Stall = state_q == FETCH ? !Imem_Ack : state_q == DISCARD;
  end
  assign IF_ID_Instr = instr_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_Valid = valid_q;
`ifdef IF_PREDECODE_EN
  logic is_ctrl_q, is_ctrl_d, dec_ctrl;
  if_predecode u_predecode (
    .instr  (instr_d),
    .is_ctrl(dec_ctrl)
  );
  assign is_ctrl_d = dec_ctrl & valid_d;
  // predecode flag follows the IF/ID entry it describes
  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) is_ctrl_q <= 1'b0;
    else is_ctrl_q <= is_ctrl_d;
  end
  assign IF_ID_IsCtrl = is_ctrl_q;
`else
  assign IF_ID_IsCtrl = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: table-driven check of fetch handshake, hold, redirect and reset
module tb_if_fetch_stage;
`ifdef IF_PREDECODE_EN
  localparam logic PD = 1'b1;
`else
  localparam logic PD = 1'b0;
`endif
  logic        Clk = 1'b0, PcReSet = 1'b1;
  logic [31:0] PC = '0, Imem_Rdata = '0;
  logic        Change_PC_en = 1'b0, Stall = 1'b0, Imem_Ack = 1'b0;
  logic        Imem_Req, Fetch_Stall, IF_ID_Valid, IF_ID_IsCtrl;
  logic [31:0] Imem_Addr, IF_ID_Instr, IF_ID_PC4;
  int          n_chk = 0, n_fail = 0;

  if_fetch_stage dut (
    .Clk(Clk), .PcReSet(PcReSet), .PC(PC), .Change_PC_en(Change_PC_en), .Stall(Stall),
    .Imem_Ack(Imem_Ack), .Imem_Rdata(Imem_Rdata), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Fetch_Stall(Fetch_Stall), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid), .IF_ID_IsCtrl(IF_ID_IsCtrl)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic        chg, stall, ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        fs;
    logic [31:0] instr, pc4;
    logic        valid, ctrl;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(logic [31:0] pc, logic chg, logic stall, logic ack, logic [31:0] rdata,
                             logic req, logic [31:0] addr, logic fs,
                             logic [31:0] instr, logic [31:0] pc4, logic valid, logic ctrl);
    vec_t r;
    r.pc = pc; r.chg = chg; r.stall = stall; r.ack = ack; r.rdata = rdata;
    r.req = req; r.addr = addr; r.fs = fs;
    r.instr = instr; r.pc4 = pc4; r.valid = valid; r.ctrl = ctrl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    @(negedge Clk);
    PC = t.pc; Change_PC_en = t.chg; Stall = t.stall; Imem_Ack = t.ack; Imem_Rdata = t.rdata;
    #1;
    chk($sformatf("v%0d req", idx), {31'b0, Imem_Req}, {31'b0, t.req});
    chk($sformatf("v%0d addr", idx), Imem_Addr, t.addr);
    chk($sformatf("v%0d fetch_stall", idx), {31'b0, Fetch_Stall}, {31'b0, t.fs});
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d instr", idx), IF_ID_Instr, t.instr);
    chk($sformatf("v%0d pc4", idx), IF_ID_PC4, t.pc4);
    chk($sformatf("v%0d valid", idx), {31'b0, IF_ID_Valid}, {31'b0, t.valid});
    chk($sformatf("v%0d isctrl", idx), {31'b0, IF_ID_IsCtrl}, {31'b0, t.ctrl & PD});
  endtask

  initial begin
    tbl[0]  = v(32'h3000, 0, 0, 1, 32'h00221820, 1, 32'h3000, 0, 32'h00221820, 32'h3004, 1, 0);
    tbl[1]  = v(32'h3004, 0, 0, 1, 32'h08000010, 1, 32'h3004, 0, 32'h08000010, 32'h3008, 1, 1);
    tbl[2]  = v(32'h3008, 0, 0, 1, 32'h03E00008, 1, 32'h3008, 0, 32'h03E00008, 32'h300C, 1, 1);
    tbl[3]  = v(32'h300C, 0, 0, 0, 32'hFFFFFFFF, 1, 32'h300C, 1, 32'h03E00008, 32'h300C, 1, 1);
    tbl[4]  = v(32'h300C, 0, 0, 1, 32'h0C000100, 1, 32'h300C, 0, 32'h0C000100, 32'h3010, 1, 1);
    tbl[5]  = v(32'h3010, 0, 1, 1, 32'h8C010004, 1, 32'h3010, 0, 32'h0C000100, 32'h3010, 1, 1);
    tbl[6]  = v(32'h3010, 0, 1, 0, 32'h0,        0, 32'h3010, 0, 32'h0C000100, 32'h3010, 1, 1);
    tbl[7]  = v(32'h3010, 0, 1, 0, 32'h0,        0, 32'h3010, 0, 32'h0C000100, 32'h3010, 1, 1);
    tbl[8]  = v(32'h3010, 0, 0, 0, 32'h0,        0, 32'h3010, 0, 32'h8C010004, 32'h3014, 1, 0);
    tbl[9]  = v(32'h3014, 0, 0, 0, 32'h0,        1, 32'h3014, 1, 32'h8C010004, 32'h3014, 1, 0);
    tbl[10] = v(32'h3014, 1, 0, 0, 32'h0,        1, 32'h3014, 1, 32'h0, 32'h0, 0, 0);
    tbl[11] = v(32'h4000, 0, 0, 0, 32'h0,        1, 32'h3014, 1, 32'h0, 32'h0, 0, 0);
    tbl[12] = v(32'h4000, 0, 0, 1, 32'hDEADBEEF, 1, 32'h3014, 1, 32'h0, 32'h0, 0, 0);
    tbl[13] = v(32'h4000, 0, 0, 1, 32'h14220002, 1, 32'h4000, 0, 32'h14220002, 32'h4004, 1, 1);
    tbl[14] = v(32'h4004, 0, 1, 1, 32'h00221820, 1, 32'h4004, 0, 32'h14220002, 32'h4004, 1, 1);
    tbl[15] = v(32'h4004, 1, 1, 0, 32'h0,        0, 32'h4004, 0, 32'h0, 32'h0, 0, 0);
    tbl[16] = v(32'h5000, 0, 0, 1, 32'h0320F809, 1, 32'h5000, 0, 32'h0320F809, 32'h5004, 1, 1);
    tbl[17] = v(32'h5004, 1, 1, 1, 32'h10000001, 1, 32'h5004, 0, 32'h0, 32'h0, 0, 0);
    tbl[18] = v(32'h6000, 0, 0, 1, 32'h24000008, 1, 32'h6000, 0, 32'h24000008, 32'h6004, 1, 0);
    tbl[19] = v(32'h6004, 1, 0, 0, 32'h0,        1, 32'h6004, 1, 32'h0, 32'h0, 0, 0);
    tbl[20] = v(32'h7000, 1, 0, 1, 32'hDEADBEEF, 1, 32'h6004, 1, 32'h0, 32'h0, 0, 0);
    tbl[21] = v(32'h8000, 0, 0, 1, 32'h10220003, 1, 32'h8000, 0, 32'h10220003, 32'h8004, 1, 1);
    tbl[22] = v(32'hFFFFFFFC, 0, 0, 1, 32'h00221820, 1, 32'hFFFFFFFC, 0, 32'h00221820, 32'h0, 1, 0);
    tbl[23] = v(32'h0,    0, 1, 0, 32'h0,        1, 32'h0,    1, 32'h00221820, 32'h0, 1, 0);
    tbl[24] = v(32'h0,    0, 0, 1, 32'h0800FFFF, 1, 32'h0,    0, 32'h0800FFFF, 32'h4, 1, 1);
    #1;
    chk("reset instr", IF_ID_Instr, 32'h0);
    chk("reset pc4", IF_ID_PC4, 32'h0);
    chk("reset valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("reset isctrl", {31'b0, IF_ID_IsCtrl}, 32'h0);
    chk("reset req", {31'b0, Imem_Req}, 32'h1);
    @(negedge Clk);
    PcReSet = 1'b0;
    for (int i = 0; i < 25; i++) run_vec(i, tbl[i]);
    @(negedge Clk);
    PC = 32'h9000; Change_PC_en = 1'b0; Stall = 1'b0; Imem_Ack = 1'b0;
    #1;
    chk("midwait fetch_stall", {31'b0, Fetch_Stall}, 32'h1);
    #1;
    PcReSet = 1'b1;
    #1;
    chk("async reset instr", IF_ID_Instr, 32'h0);
    chk("async reset pc4", IF_ID_PC4, 32'h0);
    chk("async reset valid", {31'b0, IF_ID_Valid}, 32'h0);
    chk("async reset isctrl", {31'b0, IF_ID_IsCtrl}, 32'h0);
    chk("async reset addr", Imem_Addr, 32'h9000);
    @(negedge Clk);
    PcReSet = 1'b0;
    run_vec(100, v(32'h3000, 0, 0, 1, 32'h10220003, 1, 32'h3000, 0, 32'h10220003, 32'h3004, 1, 1));
    run_vec(101, v(32'h3004, 0, 0, 1, 32'h00221820, 1, 32'h3004, 0, 32'h00221820, 32'h3008, 1, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
